// File: rtl/waveform_burst_ctrl_pkg.sv
// rtl/waveform_burst_ctrl_pkg.sv - shared FSM state encoding for the waveform burst controller
package waveform_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/waveform_burst_ctrl_period_counter.sv
// rtl/waveform_burst_ctrl_period_counter.sv - N-bit period counter with clear, load and count enable
module period_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] din,
    output logic [N-1:0] q,
    output logic         carry
);

    // Priority: clear over load over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

    assign carry = (&q) & en;

endmodule

// File: rtl/waveform_burst_ctrl.sv
// rtl/waveform_burst_ctrl.sv - square-wave generator with burst/continuous sequencing FSM
module waveform_burst_ctrl
    import waveform_burst_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic [N-1:0]  preset,
    input  logic [BW-1:0] burst,
    output logic          busy,
    output logic          tick,
    output logic          wave,
    output logic          done,
    output logic [N-1:0]  cnt
);

    state_t        state;
    state_t        next_state;
    logic [N-1:0]  preset_s;
    logic [BW-1:0] remaining;
    logic          cont_s;
    logic          wave_r;
    logic          carry;
    logic          start_ok;
    logic          last_tick;
    logic          cnt_clr;
    logic          cnt_load;
    logic          cnt_en;

    assign start_ok  = start & ~stop & (cont | (burst != '0));
    assign tick      = carry;
    assign last_tick = tick & ~cont_s & (remaining == BW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // stop wins over a coincident final tick, so no DONE pass in that case
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = LOAD;
            LOAD:    next_state = stop ? IDLE : RUN;
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (last_tick) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign cnt_clr  = (next_state == IDLE);
    assign cnt_load = (state == LOAD) | tick;
    assign cnt_en   = (state == RUN);

    period_counter #(
        .N(N)
    ) u_period_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load  (cnt_load),
        .en    (cnt_en),
        .din   (preset_s),
        .q     (cnt),
        .carry (carry)
    );

    // Shadow copies isolate the running sequence from input changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset_s  <= '0;
            remaining <= '0;
            cont_s    <= 1'b0;
        end else if (state == IDLE && start_ok) begin
            preset_s  <= preset;
            remaining <= burst;
            cont_s    <= cont;
        end else if (tick && !cont_s) begin
            remaining <= remaining - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_r <= 1'b0;
        end else if (next_state == IDLE || state == LOAD) begin
            wave_r <= 1'b0;
        end else if (tick) begin
            wave_r <= ~wave_r;
        end
    end

    assign wave = wave_r;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_waveform_burst_ctrl.sv
// tb/tb_waveform_burst_ctrl.sv - directed self-checking bench for waveform_burst_ctrl
module tb_waveform_burst_ctrl;
    import waveform_burst_ctrl_pkg::*;

    localparam int N  = 8;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          cont;
    logic [N-1:0]  preset;
    logic [BW-1:0] burst;
    logic          busy;
    logic          tick;
    logic          wave;
    logic          done;
    logic [N-1:0]  cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    waveform_burst_ctrl #(
        .N  (N),
        .BW (BW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .cont   (cont),
        .preset (preset),
        .burst  (burst),
        .busy   (busy),
        .tick   (tick),
        .wave   (wave),
        .done   (done),
        .cnt    (cnt)
    );

    task automatic launch(input logic [7:0] p, input logic [7:0] b, input logic c);
        preset = p;
        burst  = b;
        cont   = c;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, tick, wave, done} !== 4'b0000 || cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs busy=%b tick=%b wave=%b done=%b cnt=%h expected all zero", busy, tick, wave, done, cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_release busy=%b cnt=%h expected 0 00", busy, cnt);
        end
    endtask

    task automatic test_burst;
        logic       exp_tick;
        logic       exp_wave;
        logic [7:0] exp_cnt;
        launch(8'hFC, 8'd3, 1'b0);
        checks++;
        if (dut.state !== LOAD || busy !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL burst_load state=%0d busy=%b tick=%b expected %0d 1 0", dut.state, busy, tick, LOAD);
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_tick = (c % 4 == 0);
            exp_wave = 1'(((c - 1) / 4) % 2);
            exp_cnt  = 8'(8'hFC + (c - 1) % 4);
            checks++;
            if (tick !== exp_tick || wave !== exp_wave || cnt !== exp_cnt || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL burst_run cycle %0d tick=%b wave=%b cnt=%h done=%b busy=%b expected %b %b %h 0 1",
                         c, tick, wave, cnt, done, busy, exp_tick, exp_wave, exp_cnt);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || wave !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL burst_done done=%b wave=%b tick=%b expected 1 1 0", done, wave, tick);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || wave !== 1'b0 || cnt !== 8'h00) begin
            errors++;
            $display("FAIL burst_idle done=%b busy=%b wave=%b cnt=%h expected 0 0 0 00", done, busy, wave, cnt);
        end
    endtask

    task automatic test_min_period;
        launch(8'hFF, 8'd2, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++;
            if (tick !== 1'b1 || cnt !== 8'hFF || done !== 1'b0) begin
                errors++;
                $display("FAIL min_period cycle %0d tick=%b cnt=%h done=%b expected 1 ff 0", c, tick, cnt, done);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL min_period_done done=%b tick=%b expected 1 0", done, tick);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL min_period_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_continuous;
        int ntick = 0;
        int bad   = 0;
        launch(8'hF0, 8'd0, 1'b1);
        for (int c = 1; c <= 1600; c++) begin
            @(negedge clk);
            if (tick === 1'b1) ntick++;
            if (tick !== (c % 16 == 0) || done !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || ntick != 100) begin
            errors++;
            $display("FAIL continuous ticks=%0d bad_cycles=%0d expected 100 0", ntick, bad);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnt !== 8'h00 || done !== 1'b0 || wave !== 1'b0) begin
            errors++;
            $display("FAIL continuous_stop busy=%b cnt=%h done=%b wave=%b expected 0 00 0 0", busy, cnt, done, wave);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL continuous_after_stop done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_stop_final_tick;
        launch(8'hFE, 8'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (tick !== 1'b0 || cnt !== 8'hFE) begin
            errors++;
            $display("FAIL stop_tick_run1 tick=%b cnt=%h expected 0 fe", tick, cnt);
        end
        @(negedge clk);
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL stop_tick_pulse tick=%b expected 1", tick);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cnt !== 8'h00) begin
            errors++;
            $display("FAIL stop_tick_idle busy=%b done=%b cnt=%h expected 0 0 00", busy, done, cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL stop_tick_no_done done=%b expected 0", done);
        end
    endtask

    task automatic test_burst_zero;
        preset = 8'hFC;
        burst  = 8'd0;
        cont   = 1'b0;
        start  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL burst_zero cycle %0d busy=%b expected 0", c, busy);
            end
        end
        burst = 8'd3;
        stop  = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_stop busy=%b expected 0", busy);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_shadowing;
        logic [7:0] exp_cnt;
        launch(8'hFC, 8'd2, 1'b0);
        preset = 8'h00;
        burst  = 8'd9;
        cont   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_cnt = 8'(8'hFC + (c - 1) % 4);
            checks++;
            if (tick !== (c % 4 == 0) || cnt !== exp_cnt || busy !== 1'b1) begin
                errors++;
                $display("FAIL shadow_run cycle %0d tick=%b cnt=%h busy=%b expected %b %h 1", c, tick, cnt, busy, (c % 4 == 0), exp_cnt);
            end
            if (c == 2) start = 1'b1;
            if (c == 3) start = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL shadow_done done=%b expected 1", done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL shadow_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_async_reset;
        launch(8'hFC, 8'd5, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (wave !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset wave=%b busy=%b expected 1 1", wave, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, tick, wave, done} !== 4'b0000 || cnt !== 8'h00) begin
            errors++;
            $display("FAIL async_reset busy=%b tick=%b wave=%b done=%b cnt=%h expected all zero", busy, tick, wave, done, cnt);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b done=%b expected 0 0", busy, done);
        end
        launch(8'hFE, 8'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tick !== 1'b1 || wave !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_tick tick=%b wave=%b expected 1 0", tick, wave);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || wave !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done done=%b wave=%b expected 1 1", done, wave);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wave !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle2 busy=%b wave=%b expected 0 0", busy, wave);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        cont   = 1'b0;
        preset = '0;
        burst  = '0;
        test_reset();
        test_burst();
        test_min_period();
        test_continuous();
        test_stop_final_tick();
        test_burst_zero();
        test_shadowing();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
